// File: rtl/residual_arb_pkg.sv
// Shared types for the residual SRAM arbiter: requester identity, read tag and
// starvation counter width.
package residual_arb_pkg;

  localparam int STARVE_W = 3;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_HOST = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t owner;
  } rd_tag_t;

endpackage

// File: rtl/residual_port_arb.sv
// Two-requester arbiter for one SRAM port: CORE has priority, HOST takes the
// port once it has lost STARVE_LIMIT consecutive cycles.
module residual_port_arb
  import residual_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    core_req,
  input  logic    host_req,
  output logic    core_gnt,
  output logic    host_gnt,
  output req_id_t winner
);

  logic [STARVE_W-1:0] host_starve;
  logic                host_wins;

  always_comb begin
    host_wins = host_req && (!core_req || (host_starve >= STARVE_W'(STARVE_LIMIT)));
    host_gnt  = host_wins;
    core_gnt  = core_req && !host_wins;
    winner    = host_wins ? REQ_HOST : REQ_CORE;
  end

  // Saturating count of consecutive cycles HOST asked and lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      host_starve <= '0;
    end else if (host_req && !host_wins) begin
      if (host_starve != {STARVE_W{1'b1}}) host_starve <= host_starve + 1'b1;
    end else begin
      host_starve <= '0;
    end
  end

endmodule

// File: rtl/residual_sram_arbiter.sv
// Shares the residual SRAM write and read ports between CORE and HOST, registers
// the winning commands and steers read returns back to their issuer.
module residual_sram_arbiter
  import residual_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 128,
  parameter int SRAM_RD_LAT  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  core_wreq,
  input  logic [ADDR_WIDTH-1:0] core_waddr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic [DATA_WIDTH-1:0] core_bwe,
  output logic                  core_wgnt,
  input  logic                  core_rreq,
  input  logic [ADDR_WIDTH-1:0] core_raddr,
  output logic                  core_rgnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  host_wreq,
  input  logic [ADDR_WIDTH-1:0] host_waddr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic [DATA_WIDTH-1:0] host_bwe,
  output logic                  host_wgnt,
  input  logic                  host_rreq,
  input  logic [ADDR_WIDTH-1:0] host_raddr,
  output logic                  host_rgnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic [DATA_WIDTH-1:0] sram_bwe,
  output logic                  sram_ren,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int TAG_DEPTH = 1 + SRAM_RD_LAT;

  req_id_t wr_winner;
  req_id_t rd_winner;
  logic    wr_any;
  logic    rd_any;
  rd_tag_t tag_pipe [TAG_DEPTH];

  residual_port_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_wr_arb (
    .clk      (clk),
    .rstn     (rstn),
    .core_req (core_wreq),
    .host_req (host_wreq),
    .core_gnt (core_wgnt),
    .host_gnt (host_wgnt),
    .winner   (wr_winner)
  );

  residual_port_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_rd_arb (
    .clk      (clk),
    .rstn     (rstn),
    .core_req (core_rreq),
    .host_req (host_rreq),
    .core_gnt (core_rgnt),
    .host_gnt (host_rgnt),
    .winner   (rd_winner)
  );

  assign wr_any = core_wgnt || host_wgnt;
  assign rd_any = core_rgnt || host_rgnt;

  // Command stage: accepted requests become SRAM commands one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sram_wen   <= 1'b0;
      sram_waddr <= '0;
      sram_wdata <= '0;
      sram_bwe   <= '0;
      sram_ren   <= 1'b0;
      sram_raddr <= '0;
    end else begin
      sram_wen <= wr_any;
      sram_ren <= rd_any;
      if (wr_any) begin
        sram_waddr <= (wr_winner == REQ_HOST) ? host_waddr : core_waddr;
        sram_wdata <= (wr_winner == REQ_HOST) ? host_wdata : core_wdata;
        sram_bwe   <= (wr_winner == REQ_HOST) ? host_bwe   : core_bwe;
      end else begin
        sram_bwe   <= '0;
      end
      if (rd_any) sram_raddr <= (rd_winner == REQ_HOST) ? host_raddr : core_raddr;
    end
  end

  // Tag stage: owner of each in-flight read, aligned with its SRAM return.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAG_DEPTH; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= rd_tag_t'{valid: rd_any, owner: rd_winner};
      for (int i = 1; i < TAG_DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign core_rvalid = tag_pipe[TAG_DEPTH-1].valid && (tag_pipe[TAG_DEPTH-1].owner == REQ_CORE);
  assign host_rvalid = tag_pipe[TAG_DEPTH-1].valid && (tag_pipe[TAG_DEPTH-1].owner == REQ_HOST);
  assign core_rdata  = sram_rdata;
  assign host_rdata  = sram_rdata;

endmodule

// File: tb/tb_residual_sram_arbiter.sv
// Bench for residual_sram_arbiter: SRAM model, transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_residual_sram_arbiter;

  localparam int AW     = 10;
  localparam int DW     = 128;
  localparam int RD_LAT = 1;
  localparam int LIMIT  = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          core_wreq, host_wreq, core_rreq, host_rreq;
  logic [AW-1:0] core_waddr, host_waddr, core_raddr, host_raddr;
  logic [DW-1:0] core_wdata, host_wdata, core_bwe, host_bwe;
  logic          core_wgnt, host_wgnt, core_rgnt, host_rgnt;
  logic          core_rvalid, host_rvalid;
  logic [DW-1:0] core_rdata, host_rdata;
  logic          sram_wen, sram_ren;
  logic [AW-1:0] sram_waddr, sram_raddr;
  logic [DW-1:0] sram_wdata, sram_bwe, sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  residual_sram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_RD_LAT(RD_LAT), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .core_wreq(core_wreq), .core_waddr(core_waddr), .core_wdata(core_wdata),
    .core_bwe(core_bwe), .core_wgnt(core_wgnt),
    .core_rreq(core_rreq), .core_raddr(core_raddr), .core_rgnt(core_rgnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_wreq(host_wreq), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .host_bwe(host_bwe), .host_wgnt(host_wgnt),
    .host_rreq(host_rreq), .host_raddr(host_raddr), .host_rgnt(host_rgnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .sram_wen(sram_wen), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
    .sram_bwe(sram_bwe), .sram_ren(sram_ren), .sram_raddr(sram_raddr),
    .sram_rdata(sram_rdata)
  );

  function automatic logic [DW-1:0] preload(int a);
    logic [7:0] b;
    b = 8'(a);
    return (a == 'h30) ? {16{8'h11}} : {16{b}};
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAM: read samples the array before the same-edge write lands.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (sram_ren) sram_rdata <= mem[sram_raddr];
    if (sram_wen) mem[sram_waddr] <= (mem[sram_waddr] & ~sram_bwe) | (sram_wdata & sram_bwe);
  end

  // Reference model: transaction view of grants, commands and returns.
  typedef struct {
    int          due;
    bit          owner;
    logic [DW-1:0] data;
  } ret_t;

  logic [DW-1:0] shadow [1024];
  ret_t          rq [$];
  int            cyc = 0;
  int            st_w = 0, st_r = 0;
  bit            pend_v = 0;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d, pend_b;
  bit            e_wen = 0, e_ren = 0;
  logic [AW-1:0] e_waddr = '0, e_raddr = '0;
  logic [DW-1:0] e_wdata = '0, e_bwe = '0;

  always @(negedge clk) begin
    bit hw, cw, hr, cr, has;
    if (!rstn) begin
      chk("rst_sram_wen", DW'(sram_wen), '0);
      chk("rst_sram_ren", DW'(sram_ren), '0);
      chk("rst_sram_bwe", sram_bwe, '0);
      chk("rst_sram_wdata", sram_wdata, '0);
      chk("rst_sram_waddr", DW'(sram_waddr), '0);
      chk("rst_sram_raddr", DW'(sram_raddr), '0);
      chk("rst_core_rvalid", DW'(core_rvalid), '0);
      chk("rst_host_rvalid", DW'(host_rvalid), '0);
      st_w = 0; st_r = 0; pend_v = 0; rq.delete();
      e_wen = 0; e_ren = 0; e_waddr = '0; e_raddr = '0; e_wdata = '0; e_bwe = '0;
    end else begin
      if (pend_v) shadow[pend_a] = (shadow[pend_a] & ~pend_b) | (pend_d & pend_b);
      hw = host_wreq && (!core_wreq || st_w >= LIMIT);
      cw = core_wreq && !hw;
      hr = host_rreq && (!core_rreq || st_r >= LIMIT);
      cr = core_rreq && !hr;
      chk("m_core_wgnt", DW'(core_wgnt), DW'(cw));
      chk("m_host_wgnt", DW'(host_wgnt), DW'(hw));
      chk("m_core_rgnt", DW'(core_rgnt), DW'(cr));
      chk("m_host_rgnt", DW'(host_rgnt), DW'(hr));
      chk("m_sram_wen", DW'(sram_wen), DW'(e_wen));
      chk("m_sram_waddr", DW'(sram_waddr), DW'(e_waddr));
      chk("m_sram_wdata", sram_wdata, e_wdata);
      chk("m_sram_bwe", sram_bwe, e_bwe);
      chk("m_sram_ren", DW'(sram_ren), DW'(e_ren));
      chk("m_sram_raddr", DW'(sram_raddr), DW'(e_raddr));
      has = (rq.size() > 0) && (rq[0].due == cyc);
      chk("m_core_rvalid", DW'(core_rvalid), DW'(has && !rq[0].owner));
      chk("m_host_rvalid", DW'(host_rvalid), DW'(has && rq[0].owner));
      if (has) begin
        chk("m_rdata", rq[0].owner ? host_rdata : core_rdata, rq[0].data);
        void'(rq.pop_front());
      end
      e_ren = hr || cr;
      if (e_ren) begin
        e_raddr = hr ? host_raddr : core_raddr;
        rq.push_back(ret_t'{due: cyc + 1 + RD_LAT, owner: hr, data: shadow[e_raddr]});
      end
      e_wen = hw || cw;
      pend_v = e_wen;
      if (e_wen) begin
        e_waddr = hw ? host_waddr : core_waddr;
        e_wdata = hw ? host_wdata : core_wdata;
        e_bwe   = hw ? host_bwe : core_bwe;
        pend_a = e_waddr; pend_d = e_wdata; pend_b = e_bwe;
      end else begin
        e_bwe = '0;
      end
      st_w = (host_wreq && !hw) ? ((st_w < 7) ? st_w + 1 : 7) : 0;
      st_r = (host_rreq && !hr) ? ((st_r < 7) ? st_r + 1 : 7) : 0;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = preload(i);
      shadow[i] = preload(i);
    end
    sram_rdata = '0;
    rstn = 1'b0;
    core_wreq = 0; host_wreq = 0; core_rreq = 0; host_rreq = 0;
    core_waddr = '0; host_waddr = '0; core_raddr = '0; host_raddr = '0;
    core_wdata = '0; host_wdata = '0; core_bwe = '0; host_bwe = '0;
    repeat (2) tick();
    tick(); rstn = 1'b1;
    repeat (2) tick();

    // CORE-only read of 0x010
    core_rreq = 1; core_raddr = 10'h010;
    @(negedge clk); chk("core_rd_gnt", DW'(core_rgnt), DW'(1));
    tick(); core_rreq = 0;
    @(negedge clk);
    chk("core_rd_ren", DW'(sram_ren), DW'(1));
    chk("core_rd_raddr", DW'(sram_raddr), DW'(10'h010));
    tick();
    @(negedge clk);
    chk("core_rd_rvalid", DW'(core_rvalid), DW'(1));
    chk("core_rd_data", core_rdata, {16{8'h10}});
    chk("core_rd_host_rvalid", DW'(host_rvalid), DW'(0));
    tick();

    // Continuous read contention: HOST wins every fifth cycle
    core_rreq = 1; core_raddr = 10'h005; host_rreq = 1; host_raddr = 10'h006;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("cont_host_rgnt", DW'(host_rgnt), DW'((k % 5) == 4));
      chk("cont_core_rgnt", DW'(core_rgnt), DW'((k % 5) != 4));
      tick();
    end
    core_rreq = 0; host_rreq = 0;
    repeat (3) tick();

    // Back-to-back mixed reads
    core_rreq = 1; core_raddr = 10'd1;
    @(negedge clk); tick();
    core_rreq = 0; host_rreq = 1; host_raddr = 10'd2;
    @(negedge clk); tick();
    host_rreq = 0; core_rreq = 1; core_raddr = 10'd3;
    @(negedge clk);
    chk("b2b_core_rvalid0", DW'(core_rvalid), DW'(1));
    chk("b2b_core_data0", core_rdata, {16{8'h01}});
    tick(); core_rreq = 0;
    @(negedge clk);
    chk("b2b_host_rvalid", DW'(host_rvalid), DW'(1));
    chk("b2b_host_data", host_rdata, {16{8'h02}});
    tick();
    @(negedge clk);
    chk("b2b_core_rvalid1", DW'(core_rvalid), DW'(1));
    chk("b2b_core_data1", core_rdata, {16{8'h03}});
    tick();

    // Write contention on 0x20
    core_wreq = 1; core_waddr = 10'h020; core_wdata = {16{8'hAA}}; core_bwe = '1;
    host_wreq = 1; host_waddr = 10'h020; host_wdata = {16{8'h55}}; host_bwe = '1;
    @(negedge clk);
    chk("wc_core_wgnt", DW'(core_wgnt), DW'(1));
    chk("wc_host_wgnt0", DW'(host_wgnt), DW'(0));
    tick(); core_wreq = 0;
    @(negedge clk);
    chk("wc_host_wgnt1", DW'(host_wgnt), DW'(1));
    chk("wc_wen0", DW'(sram_wen), DW'(1));
    chk("wc_wdata0", sram_wdata, {16{8'hAA}});
    chk("wc_waddr0", DW'(sram_waddr), DW'(10'h020));
    tick(); host_wreq = 0;
    @(negedge clk);
    chk("wc_wen1", DW'(sram_wen), DW'(1));
    chk("wc_wdata1", sram_wdata, {16{8'h55}});
    tick();
    @(negedge clk);
    chk("wc_idle_wen", DW'(sram_wen), DW'(0));
    chk("wc_idle_bwe", sram_bwe, '0);
    chk("wc_idle_wdata", sram_wdata, {16{8'h55}});

    // Partial byte-enable write, then read back both addresses
    core_wreq = 1; core_waddr = 10'h040; core_wdata = '1; core_bwe = {64'h0, {64{1'b1}}};
    tick(); core_wreq = 0; core_rreq = 1; core_raddr = 10'h040;
    tick(); core_rreq = 0; host_rreq = 1; host_raddr = 10'h020;
    tick(); host_rreq = 0;
    @(negedge clk); chk("pbwe_data", core_rdata, {{8{8'h40}}, {8{8'hFF}}});
    tick();
    @(negedge clk); chk("pbwe_host_data", host_rdata, {16{8'h55}});
    tick();

    // Same-cycle write and read of 0x30: read sees old content
    core_wreq = 1; core_waddr = 10'h030; core_wdata = {16{8'h77}}; core_bwe = '1;
    host_rreq = 1; host_raddr = 10'h030;
    @(negedge clk);
    chk("sa_core_wgnt", DW'(core_wgnt), DW'(1));
    chk("sa_host_rgnt", DW'(host_rgnt), DW'(1));
    tick(); core_wreq = 0; host_rreq = 0;
    tick();
    @(negedge clk);
    chk("sa_host_rvalid", DW'(host_rvalid), DW'(1));
    chk("sa_old_data", host_rdata, {16{8'h11}});
    tick(); core_rreq = 1; core_raddr = 10'h030;
    tick(); core_rreq = 0;
    tick();
    @(negedge clk); chk("sa_new_data", core_rdata, {16{8'h77}});
    tick();

    // Reset while a HOST read is in flight
    host_rreq = 1; host_raddr = 10'h007;
    @(negedge clk); chk("rr_host_rgnt", DW'(host_rgnt), DW'(1));
    tick(); host_rreq = 0; rstn = 1'b0;
    @(negedge clk);
    chk("rr_ren", DW'(sram_ren), DW'(0));
    chk("rr_wen", DW'(sram_wen), DW'(0));
    tick(); rstn = 1'b1;
    @(negedge clk);
    chk("rr_host_rvalid0", DW'(host_rvalid), DW'(0));
    chk("rr_ren_after", DW'(sram_ren), DW'(0));
    tick();
    @(negedge clk); chk("rr_host_rvalid1", DW'(host_rvalid), DW'(0));
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
